instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Instruction fetch stage with prefetch queue; sits upstream of instruction_decoder.
//  Owns the fetch PC and issues one read per cycle to instruction memory (1-cycle latency).
//  Buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands them to decode over valid/ready.
//  A branch redirect flushes the queue, discards the in-flight fetch and restarts at the new PC.
// PARAMETERS
//  DEPTH     4       prefetch FIFO entries (>=2)
//  RESET_PC  32'h0   fetch PC loaded on reset
//  PC_STEP   4       PC increment per fetched instruction
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  nreset          in   1   synchronous reset, active low
//  imem_req        out  1   read strobe to instruction memory
//  imem_addr       out  32  read address (= fetch PC)
//  imem_rdata      in   32  read data, valid the cycle after imem_req
//  redirect_valid  in   1   branch taken; load redirect_pc, flush
//  redirect_pc     in   32  branch target
//  out_valid       out  1   head entry valid to decode
//  out_ready       in   1   decode accepts head when out_valid & out_ready
//  out_instr       out  32  head instruction
//  out_pc          out  32  PC of head instruction
//  occupancy       out  $clog2(DEPTH+1)  valid FIFO entries
// BEHAVIOUR
//  One clock; reset is synchronous and active-low (nreset sampled on rising clk).
//  Reset: fetch_pc=RESET_PC, FIFO empty, inflight=0, occupancy=0; while nreset=0
//   imem_req=0, out_valid=0, out_instr=0, out_pc=0.
//  pop = out_valid & out_ready. out_valid = ~empty & ~redirect_valid (no pop in redirect cycle).
//  imem_req = nreset & ~redirect_valid & (occupancy + inflight - pop < DEPTH); imem_addr = fetch_pc.
//  On imem_req: fetch_pc += PC_STEP (mod 2^32, wraps silently); inflight<=1, tag<=issued PC.
//   No imem_req: inflight<=0.
//  Response: cycle after a non-killed request, {tag, imem_rdata} pushed at tail at that edge.
//  Latency: request in cycle N -> out_valid in cycle N+2 (no bypass). Throughput 1/cycle.
//  Push and pop in same cycle: both occur, occupancy unchanged.
//  Full: credit rule guarantees a push never meets a full FIFO; overflow is a design error (assert).
//  Empty: out_valid=0; out_instr/out_pc hold last values (don't-care).
//  Redirect cycle: FIFO cleared, inflight response killed (not pushed next cycle),
//   fetch_pc<=redirect_pc, imem_req=0. Next cycle requests redirect_pc; first redirected
//   instruction on out_valid 2 cycles after that request (3 after redirect).
//  Redirect on consecutive cycles: last one wins; each kills prior state.
//  Reset mid-operation overrides redirect and all traffic; no stale entry survives.
//  Pointers: read/write indices mod DEPTH; occupancy is an explicit counter 0..DEPTH.
// TESTING
//  Reset release, out_ready=1, imem returns 0xE000_0000+addr -> out_pc 0,4,8,C in order, first out_valid 2 cycles after release.
//  out_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req drops to 0, no push lost; resume gives contiguous PCs.
//  Redirect to 0x100 while 1 in-flight + 3 queued -> next accepted out_pc 0x100,0x104; zero stale PCs leak.
//  redirect_valid with out_ready=1 and nonempty FIFO -> out_valid=0 that cycle, nothing popped, FIFO empty next cycle.
//  RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
//  nreset low for 1 cycle mid-stream with FIFO full -> occupancy=0, out_valid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction memory read port, branch redirect and decode handoff.
// master = the fetch queue; slave = the surrounding memory/decode/branch logic.
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [OW-1:0] occupancy;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc, occupancy
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc, occupancy
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner + DEPTH-entry {pc, instr} prefetch FIFO; request->out_valid is 2 cycles, redirect->first new out_valid 3.
// Backpressure: a fetch is issued only when queued + in-flight - popped leaves room, so pushes never meet a full FIFO.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                nreset,
  instr_fetch_queue_if.master bus
);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic          head_vld, pop, push, req;
  logic [OW:0]   committed;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_vld  = nreset && (occ_q != '0) && !bus.redirect_valid;
    pop       = head_vld && bus.out_ready;
    // Slots already spoken for once this cycle's response lands and the head leaves.
    committed = {1'b0, occ_q} + (OW+1)'(inflight_q) - (OW+1)'(pop);
    req       = nreset && !bus.redirect_valid && (committed < (OW+1)'(DEPTH));
    push      = inflight_q && !bus.redirect_valid;

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;

    if (bus.redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q].pc    = tag_q;
        mem_d[wr_ptr_q].instr = bus.imem_rdata;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + OW'(push) - OW'(pop);
      if (req) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        tag_d      = fetch_pc_q;
        inflight_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage is data-path only; occupancy and pointers decide what is meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = head_vld;
  assign bus.out_instr = nreset ? mem_q[rd_ptr_q].instr : '0;
  assign bus.out_pc    = nreset ? mem_q[rd_ptr_q].pc    : '0;
  assign bus.occupancy = occ_q;

  no_overflow_a: assert property (@(posedge clk) disable iff (!nreset)
    !(push && !pop && occ_q == OW'(DEPTH)));
endmodule
